multdiv_unit: RTL and testbench

//  Iterative signed 32-bit multiplier/divider sitting beside the X stage.

---
 rtl/multdiv_unit.sv | 172 +++++++++++++++++
 tb/tb_multdiv_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier/divider: one shift-add or restoring-divide step per cycle,
// with a one-cycle completion strobe and overflow / divide-by-zero reporting.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH:0]       mplier_q, mplier_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH:0]       dsr_q, dsr_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic                 neg_q, neg_d;
  logic                 div_zero_q, div_zero_d;
  logic                 div_ovf_q, div_ovf_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;

  logic                 start;
  logic [WIDTH:0]       mag_a, mag_b;
  logic [WIDTH:0]       rem_shift;
  logic [2*WIDTH-1:0]   prod_signed;
  logic [WIDTH-1:0]     quo_signed;

  // Magnitude needs WIDTH+1 bits so the most negative operand stays representable.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? (~ext + {{WIDTH{1'b0}}, 1'b1}) : ext;
  endfunction

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    dsr_d      = dsr_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    neg_d      = neg_q;
    div_zero_d = div_zero_q;
    div_ovf_d  = div_ovf_q;
    result_d   = result_q;
    exc_d      = exc_q;

    start       = ctrl_MULT | ctrl_DIV;
    mag_a       = magnitude(data_operandA);
    mag_b       = magnitude(data_operandB);
    rem_shift   = {rem_q, dvd_q[WIDTH-1]};
    prod_signed = neg_q ? (~prod_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_q;
    quo_signed  = neg_q ? (~quo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d    = ctrl_MULT ? S_MULT : S_DIV;
          count_d    = '0;
          neg_d      = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          mcand_d    = {{(WIDTH-1){1'b0}}, mag_a};
          mplier_d   = mag_b;
          prod_d     = '0;
          dvd_d      = mag_a[WIDTH-1:0];
          dsr_d      = mag_b;
          rem_d      = '0;
          quo_d      = '0;
          div_zero_d = (data_operandB == '0);
          div_ovf_d  = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
        end
      end
      S_MULT: begin
        if (count_q == CW'(WIDTH)) begin
          state_d  = S_DONE;
          result_d = prod_signed[WIDTH-1:0];
          exc_d    = (prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}});
        end else begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
        end
      end
      S_DIV: begin
        if (count_q == CW'(WIDTH)) begin
          state_d = S_DONE;
          if (div_zero_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else if (div_ovf_q) begin
            result_d = {1'b1, {(WIDTH-1){1'b0}}};
            exc_d    = 1'b1;
          end else begin
            result_d = quo_signed;
            exc_d    = 1'b0;
          end
        end else begin
          // Restoring step: bring down the next dividend bit, subtract if it fits.
          dvd_d = dvd_q << 1;
          if (rem_shift >= dsr_q) begin
            rem_d = WIDTH'(rem_shift - dsr_q);
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      dsr_q      <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= '0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      dsr_q      <= dsr_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == S_DONE);
  assign busy           = (state_q == S_MULT) || (state_q == S_DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed spec cases plus randomized operations checked
// against a plain-arithmetic signed reference.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Reference: full-precision signed arithmetic, exception from range/zero rules.
  function automatic void ref_model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    longint pa, pb, p, q;
    logic [31:0] lo;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    if (is_mult) begin
      p  = pa * pb;
      lo = p[31:0];
      r  = lo;
      e  = (p != longint'($signed(lo)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = pa / pb;
      r = q[31:0];
      e = 1'b0;
    end
  endfunction

  // Counts edges until the ready strobe is seen, bounded to 40.
  task automatic wait_rdy(output int lat);
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!data_resultRDY && lat < 40);
  endtask

  task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e, output int lat);
    @(negedge clock);
    ctrl_MULT = is_mult;
    ctrl_DIV  = !is_mult;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    wait_rdy(lat);
    r = data_result;
    e = data_exception;
    $display("op %s a=%h b=%h -> result=%h exc=%0d lat=%0d",
             is_mult ? "mul" : "div", a, b, r, e, lat);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b expected all zero",
               data_result, data_exception, data_resultRDY, busy);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b expected 0 0", busy, data_resultRDY);
    end
  endtask

  task automatic test_mult_directed();
    logic [31:0] a_t [3] = '{32'd7, 32'h0001_0000, 32'h8000_0000};
    logic [31:0] b_t [3] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1};
    logic [31:0] r_t [3] = '{32'hFFFF_FFEB, 32'd0, 32'h8000_0000};
    logic        e_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] r;
    logic e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, a_t[i], b_t[i], r, e, lat);
      checks++;
      if (lat !== 33) begin
        errors++;
        $display("FAIL mult_latency[%0d]: got %0d expected 33", i, lat);
      end
      checks++;
      if (r !== r_t[i] || e !== e_t[i]) begin
        errors++;
        $display("FAIL mult_result[%0d]: got %h/%b expected %h/%b", i, r, e, r_t[i], e_t[i]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL mult_busy_in_done[%0d]: got %b expected 0", i, busy);
      end
      @(posedge clock); #1;
      checks++;
      if (data_resultRDY !== 1'b0 || data_result !== r_t[i] || data_exception !== e_t[i]) begin
        errors++;
        $display("FAIL mult_hold[%0d]: got rdy=%b res=%h exc=%b expected rdy=0 res=%h exc=%b",
                 i, data_resultRDY, data_result, data_exception, r_t[i], e_t[i]);
      end
    end
  endtask

  task automatic test_div_directed();
    logic [31:0] a_t [5] = '{32'd100, 32'hFFFF_FF9C, 32'd5, 32'd42, 32'h8000_0000};
    logic [31:0] b_t [5] = '{32'hFFFF_FFF9, 32'd7, 32'd10, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] r_t [5] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd0, 32'd0, 32'h8000_0000};
    logic        e_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] r;
    logic e;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, a_t[i], b_t[i], r, e, lat);
      checks++;
      if (lat !== 33) begin
        errors++;
        $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat);
      end
      checks++;
      if (r !== r_t[i] || e !== e_t[i]) begin
        errors++;
        $display("FAIL div_result[%0d]: got %h/%b expected %h/%b", i, r, e, r_t[i], e_t[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [31:0] r;
    logic e;
    int lat;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    data_operandA = 32'd6;
    data_operandB = 32'd3;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    wait_rdy(lat);
    r = data_result;
    e = data_exception;
    $display("op both a=6 b=3 -> result=%h exc=%0d lat=%0d", r, e, lat);
    checks++;
    if (r !== 32'd18 || e !== 1'b0 || lat !== 33) begin
      errors++;
      $display("FAIL priority_mult: got %h/%b lat=%0d expected 00000012/0 lat=33", r, e, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL busy_mid_op: got busy=%b rdy=%b expected 1 0", busy, data_resultRDY);
    end
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    wait_rdy(lat);
    lat += 10;
    r = data_result;
    $display("op mul a=3 b=4 (ignored div) -> result=%h exc=%0d lat=%0d", r, data_exception, lat);
    checks++;
    if (r !== 32'd12 || data_exception !== 1'b0 || lat !== 33) begin
      errors++;
      $display("FAIL ignore_start_busy: got %h/%b lat=%0d expected 0000000c/0 lat=33",
               r, data_exception, lat);
    end
    // Still inside the DONE cycle: launch the next operation.
    ctrl_MULT = 1'b1;
    data_operandA = 32'hFFFF_FFFB;
    data_operandB = 32'd6;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    checks++;
    if (busy !== 1'b1 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b rdy=%b expected 1 0", busy, data_resultRDY);
    end
    wait_rdy(lat);
    r = data_result;
    $display("op mul a=fffffffb b=6 -> result=%h exc=%0d lat=%0d", r, data_exception, lat);
    checks++;
    if (r !== 32'hFFFF_FFE2 || data_exception !== 1'b0 || lat !== 33) begin
      errors++;
      $display("FAIL back_to_back: got %h/%b lat=%0d expected ffffffe2/0 lat=33",
               r, data_exception, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic e;
    int lat;
    bit saw_rdy;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (14) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b res=%h exc=%b rdy=%b expected all zero",
               busy, data_result, data_exception, data_resultRDY);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    saw_rdy = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) saw_rdy = 1'b1;
    end
    checks++;
    if (saw_rdy !== 1'b0) begin
      errors++;
      $display("FAIL no_strobe_after_abort: got rdy seen=%b expected 0", saw_rdy);
    end
    run_op(1'b1, 32'd9, 32'd9, r, e, lat);
    checks++;
    if (r !== 32'd81 || e !== 1'b0 || lat !== 33) begin
      errors++;
      $display("FAIL restart_after_reset: got %h/%b lat=%0d expected 00000051/0 lat=33", r, e, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] specials [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_0000};
    logic [31:0] a, b, r, er;
    logic e, ee;
    bit is_mult;
    int lat;
    for (int i = 0; i < 60; i++) begin
      is_mult = $urandom_range(1, 0) == 1;
      a = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : $urandom;
      b = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : $urandom;
      if (!is_mult && $urandom_range(1, 0) == 1) b = b >> $urandom_range(31, 8);
      ref_model(is_mult, a, b, er, ee);
      run_op(is_mult, a, b, r, e, lat);
      checks++;
      if (r !== er || e !== ee || lat !== 33) begin
        errors++;
        $display("FAIL random[%0d] %s %h,%h: got %h/%b lat=%0d expected %h/%b lat=33",
                 i, is_mult ? "mul" : "div", a, b, r, e, lat, er, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
